// File: rtl/preem_filter.sv
// Pre-emphasis filter: y[n] = x[n] - x[n-1] + (x[n-1] >>> SHIFT), i.e. a
// first-order high-pass with coefficient 1 - 2^-SHIFT, over frames of
// FRAME_LEN samples. Valid/ready on both sides, one-cycle latency, and an
// IDLE/RUN/DRAIN controller that gates input acceptance on enable.
module preem_filter #(
    parameter int FRAME_LEN = 160,
    parameter int SHIFT     = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [10:0] in_data,
    input  logic        in_sync,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [16:0] out_data,
    output logic [7:0]  out_idx,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    state_t             state_r;
    logic signed [16:0] xp_r;
    logic [7:0]         cnt_r;
    logic               out_valid_r;
    logic signed [16:0] out_data_r;
    logic [7:0]         out_idx_r;

    logic               in_ready_s;
    logic               in_xfer_s;
    logic               out_xfer_s;
    logic signed [16:0] xe_s;
    logic signed [16:0] xp_sel_s;
    logic signed [16:0] result_s;
    logic [7:0]         idx_s;
    logic [7:0]         cnt_next_s;

    // Input acceptance: only in RUN, and only when the output slot is free or draining this cycle.
    always_comb begin
        in_ready_s = 1'b0;
        if (state_r == RUN) begin
            in_ready_s = !out_valid_r || out_ready;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign in_xfer_s  = in_valid && in_ready_s;
    assign out_xfer_s = out_valid_r && out_ready;

    // Filter arithmetic and frame index of the sample being accepted.
    always_comb begin
        xe_s       = {{6{in_data[10]}}, in_data};
        xp_sel_s   = xp_r;
        idx_s      = cnt_r;
        cnt_next_s = 8'd0;
        if (in_sync) begin
            // A frame start clears the history and restarts indexing.
            xp_sel_s = 17'sd0;
            idx_s    = 8'd0;
        end else begin
            xp_sel_s = xp_r;
            idx_s    = cnt_r;
        end
        result_s = xe_s - xp_sel_s + (xp_sel_s >>> SHIFT);
        if (idx_s == LAST_IDX) begin
            cnt_next_s = 8'd0;
        end else begin
            cnt_next_s = idx_s + 8'd1;
        end
    end

    // Run-permission controller; DRAIN lets a pending output leave before IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (enable) begin
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!out_valid_r || out_xfer_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Filter history and sample counter advance only on accepted inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xp_r  <= 17'sd0;
            cnt_r <= 8'd0;
        end else if (in_xfer_s) begin
            xp_r  <= xe_s;
            cnt_r <= cnt_next_s;
        end
    end

    // Output slot: loaded on input transfer, emptied on output transfer, held otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= 17'sd0;
            out_idx_r   <= 8'd0;
        end else if (in_xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= result_s;
            out_idx_r   <= idx_s;
        end else if (out_xfer_s) begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_idx    = out_idx_r;
    // Pulse coincides with the downstream acceptance of the frame's last sample.
    assign frame_done = out_xfer_s && (out_idx_r == LAST_IDX);

endmodule

// File: tb/tb_preem_filter.sv
// Self-checking bench for preem_filter: directed scenarios followed by a
// randomized phase, all checked against a queue-based reference model.
module tb_preem_filter;

    localparam int FL = 4;
    localparam int SH = 5;

    typedef logic [16:0] d17_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [10:0] in_data = 11'd0;
    logic        in_sync = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [16:0] out_data;
    logic [7:0]  out_idx;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    d17_t exp_data_q[$];
    int   exp_idx_q[$];
    d17_t obs_data_q[$];
    int   obs_idx_q[$];
    int   obs_fd_q[$];
    int   xp_m = 0;
    int   cnt_m = 0;

    preem_filter #(.FRAME_LEN(FL), .SHIFT(SH)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sync(in_sync),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Floor division by 2^SH (rounds toward minus infinity).
    function automatic int floor_div(input int v);
        int d;
        d = 1 << SH;
        if (v >= 0) return v / d;
        else return -((-v + d - 1) / d);
    endfunction

    // Reference model and scoreboard, sampled mid-cycle away from the clock edge.
    always @(negedge clk) begin
        int   xe, prev, idx, r, ei;
        d17_t ed;
        logic fd_exp;
        if (!rst_n) begin
            exp_data_q.delete();
            exp_idx_q.delete();
            xp_m  = 0;
            cnt_m = 0;
        end else begin
            fd_exp = 1'b0;
            chk("out_valid_vs_model", 32'(out_valid), 32'(exp_data_q.size() != 0));
            if (out_valid && out_ready && exp_data_q.size() != 0) begin
                ed = exp_data_q.pop_front();
                ei = exp_idx_q.pop_front();
                chk("out_data", 32'(out_data), 32'(ed));
                chk("out_idx", 32'(out_idx), 32'(ei));
                fd_exp = (ei == FL - 1);
                obs_data_q.push_back(out_data);
                obs_idx_q.push_back(int'(out_idx));
                obs_fd_q.push_back(int'(frame_done));
            end
            chk("frame_done", 32'(frame_done), 32'(fd_exp));
            if (in_valid && in_ready) begin
                xe   = int'($signed(in_data));
                prev = in_sync ? 0 : xp_m;
                idx  = in_sync ? 0 : cnt_m;
                r    = xe - prev + floor_div(prev);
                exp_data_q.push_back(d17_t'(r));
                exp_idx_q.push_back(idx);
                xp_m  = xe;
                cnt_m = (idx + 1) % FL;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [10:0] v, input logic s);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = v;
        in_sync  = s;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        chk("send_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
        in_sync  = 1'b0;
    endtask

    task automatic clear_obs();
        obs_data_q.delete();
        obs_idx_q.delete();
        obs_fd_q.delete();
    endtask

    task automatic chk_obs(input string tag, input int k, input d17_t d, input int idx);
        if (k < obs_data_q.size()) begin
            chk({tag, "_data"}, 32'(obs_data_q[k]), 32'(d));
            chk({tag, "_idx"}, 32'(obs_idx_q[k]), 32'(idx));
        end else begin
            chk({tag, "_missing"}, 32'(obs_data_q.size()), 32'(k + 1));
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        enable = 1'b1;
        out_ready = 1'b1;

        // Basic filtering
        clear_obs();
        send(11'd100, 1'b1);
        send(11'd100, 1'b0);
        send(11'd100, 1'b0);
        cyc(3);
        chk_obs("basic0", 0, 17'd100, 0);
        chk_obs("basic1", 1, 17'd3, 1);
        chk_obs("basic2", 2, 17'd3, 2);

        // Negative input (also a short-frame restart at index 0)
        clear_obs();
        send(11'h400, 1'b1);
        send(11'h3FF, 1'b0);
        cyc(3);
        chk_obs("neg0", 0, 17'h1FC00, 0);
        chk_obs("neg1", 1, 17'd2015, 1);

        // Backpressure: output held for 5 cycles, no input taken
        clear_obs();
        out_ready = 1'b0;
        send(11'd7, 1'b1);
        in_valid = 1'b1;
        in_data  = 11'd8;
        in_sync  = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_data", 32'(out_data), 32'd7);
            chk("bp_out_idx", 32'(out_idx), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(11'd8, 1'b0);
        send(11'd9, 1'b0);
        cyc(3);
        chk("bp_count", 32'(obs_data_q.size()), 32'd3);
        chk_obs("bp0", 0, 17'd7, 0);
        chk_obs("bp1", 1, 17'd1, 1);
        chk_obs("bp2", 2, 17'd1, 2);

        // Frame wrap with FRAME_LEN=4
        clear_obs();
        send(11'($urandom), 1'b1);
        for (int i = 0; i < 8; i++) send(11'($urandom), 1'b0);
        cyc(3);
        chk("wrap_count", 32'(obs_idx_q.size()), 32'd9);
        for (int k = 0; k < 9; k++) begin
            if (k < obs_idx_q.size()) begin
                chk("wrap_idx", 32'(obs_idx_q[k]), 32'(k % FL));
                chk("wrap_fd", 32'(obs_fd_q[k]), 32'(k == 3 || k == 7));
            end
        end

        // Reset mid-stream with a pending output
        clear_obs();
        out_ready = 1'b0;
        send(11'd20, 1'b1);
        @(negedge clk);
        chk("mrst_pre_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        send(11'd50, 1'b0);
        cyc(2);
        chk_obs("mrst", 0, 17'd50, 0);

        // Enable drop with a pending output, then resume
        clear_obs();
        out_ready = 1'b0;
        send(11'd40, 1'b1);
        enable = 1'b0;
        @(negedge clk);
        chk("drop_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("drain_in_ready", 32'(in_ready), 32'd0);
        chk("drain_out_valid", 32'(out_valid), 32'd1);
        chk("drain_out_data", 32'(out_data), 32'd40);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 11'd10;
        in_sync   = 1'b0;
        @(negedge clk);
        chk("drain_in_ready_or", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        enable = 1'b1;
        send(11'd10, 1'b0);
        cyc(3);
        chk_obs("drop0", 0, 17'd40, 0);
        chk_obs("drop1", 1, 17'h1FFE3, 1);

        // Randomized traffic with enable toggling
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 11'($urandom);
            in_sync   = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) enable = ~enable;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_sync   = 1'b0;
        enable    = 1'b1;
        out_ready = 1'b1;
        cyc(5);
        @(negedge clk);
        chk("final_model_empty", 32'(exp_data_q.size()), 32'd0);
        chk("final_out_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
